// File: rtl/adder_display_sequencer.sv
// -----------------------------------------------------------------------------
// adder_display_sequencer
//
// Control block for the 4-bit adder result display. On an accepted go it
// latches A/B/Cin, spends one cycle (CALC) forming the 5-bit sum, then
// time-multiplexes the 4-bit sum and the zero-extended carry-out onto the
// shared digit bus, switching digits every REFRESH_CNT cycles.
//
// Ports:
//   clk    in   system clock, rising edge
//   reset  in   synchronous active-high reset
//   go     in   single-cycle start strobe (latches operands)
//   clear  in   synchronous return to IDLE, blanks the display
//   A, B   in   4-bit operands
//   Cin    in   carry-in
//   O      out  digit value (sum in SHOW_S, {3'b000,cout} in SHOW_C, else 0)
//   Sel    out  result select, 1 = sum, 0 = carry
//   an     out  active-low digit enables, an[0] = sum, an[1] = carry
//   busy   out  high during CALC
//   valid  out  high during SHOW_S / SHOW_C
//   done   out  one-cycle pulse in the first SHOW_S cycle after CALC
//
// All outputs are registers loaded from the next-state decode, so they
// reflect the registered state exactly and have no path from the inputs.
// -----------------------------------------------------------------------------
module adder_display_sequencer #(
    parameter int REFRESH_CNT = 100000,
    parameter int CNT_W       = 17
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       go,
    input  logic       clear,
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       Cin,
    output logic [3:0] O,
    output logic       Sel,
    output logic [1:0] an,
    output logic       busy,
    output logic       valid,
    output logic       done
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CALC   = 2'd1,
        ST_SHOW_S = 2'd2,
        ST_SHOW_C = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_CNT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           state_r;
    state_t           state_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_s;
    logic [3:0]       a_r;
    logic [3:0]       b_r;
    logic             cin_r;
    logic [3:0]       sum_r;
    logic             cout_r;

    logic             latch_s;
    logic             term_s;
    logic [4:0]       calc_s;
    logic [4:0]       res_s;

    logic [3:0]       o_s;
    logic             sel_s;
    logic [1:0]       an_s;
    logic             busy_s;
    logic             valid_s;
    logic             done_s;

    logic [3:0]       o_r;
    logic             sel_r;
    logic [1:0]       an_r;
    logic             busy_r;
    logic             valid_r;
    logic             done_r;

    assign calc_s = {1'b0, a_r} + {1'b0, b_r} + {4'b0000, cin_r};
    assign term_s = (cnt_r == CNT_LAST);

    // Next-state, refresh counter, operand-latch and result-update decode.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        latch_s = 1'b0;
        res_s   = {cout_r, sum_r};
        if (clear) begin
            state_s = ST_IDLE;
            cnt_s   = '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (go) begin
                        latch_s = 1'b1;
                        state_s = ST_CALC;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_CALC: begin
                    // go is ignored here; the already-latched operands are used
                    res_s   = calc_s;
                    state_s = ST_SHOW_S;
                    cnt_s   = '0;
                end
                ST_SHOW_S, ST_SHOW_C: begin
                    if (go) begin
                        latch_s = 1'b1;
                        state_s = ST_CALC;
                        cnt_s   = '0;
                    end else if (term_s) begin
                        cnt_s   = '0;
                        state_s = (state_r == ST_SHOW_S) ? ST_SHOW_C : ST_SHOW_S;
                    end else begin
                        cnt_s   = cnt_r + CNT_ONE;
                    end
                end
                default: begin
                    state_s = ST_IDLE;
                    cnt_s   = '0;
                end
            endcase
        end
    end

    // Output decode of the upcoming state, loaded into the output registers.
    always_comb begin
        o_s     = 4'h0;
        sel_s   = 1'b0;
        an_s    = 2'b11;
        busy_s  = 1'b0;
        valid_s = 1'b0;
        done_s  = 1'b0;
        case (state_s)
            ST_IDLE: begin
                an_s = 2'b11;
            end
            ST_CALC: begin
                busy_s = 1'b1;
            end
            ST_SHOW_S: begin
                o_s     = res_s[3:0];
                sel_s   = 1'b1;
                an_s    = 2'b10;
                valid_s = 1'b1;
                done_s  = (state_r == ST_CALC);
            end
            ST_SHOW_C: begin
                o_s     = {3'b000, res_s[4]};
                an_s    = 2'b01;
                valid_s = 1'b1;
            end
            default: begin
                an_s = 2'b11;
            end
        endcase
    end

    // State, counter, operand, result and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
            cnt_r   <= '0;
            a_r     <= 4'h0;
            b_r     <= 4'h0;
            cin_r   <= 1'b0;
            sum_r   <= 4'h0;
            cout_r  <= 1'b0;
            o_r     <= 4'h0;
            sel_r   <= 1'b0;
            an_r    <= 2'b11;
            busy_r  <= 1'b0;
            valid_r <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            if (latch_s) begin
                a_r   <= A;
                b_r   <= B;
                cin_r <= Cin;
            end else begin
                a_r   <= a_r;
                b_r   <= b_r;
                cin_r <= cin_r;
            end
            sum_r   <= res_s[3:0];
            cout_r  <= res_s[4];
            o_r     <= o_s;
            sel_r   <= sel_s;
            an_r    <= an_s;
            busy_r  <= busy_s;
            valid_r <= valid_s;
            done_r  <= done_s;
        end
    end

    assign O     = o_r;
    assign Sel   = sel_r;
    assign an    = an_r;
    assign busy  = busy_r;
    assign valid = valid_r;
    assign done  = done_r;

endmodule

// File: tb/tb_adder_display_sequencer.sv
// -----------------------------------------------------------------------------
// tb_adder_display_sequencer
//
// Drives two instances (REFRESH_CNT = 4 and REFRESH_CNT = 1) with the same
// stimulus: a directed sequence followed by randomized go/clear/reset traffic.
// A behavioural model tracks mode (idle / calc / show), the latched operands,
// the result and the number of cycles spent showing; the displayed digit is
// derived from (cycles_shown / REFRESH_CNT) mod 2.
// -----------------------------------------------------------------------------
module tb_adder_display_sequencer;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       go;
    logic       clear;
    logic [3:0] a;
    logic [3:0] b;
    logic       cin;

    logic [3:0] o4;
    logic       sel4;
    logic [1:0] an4;
    logic       busy4;
    logic       valid4;
    logic       done4;
    logic [3:0] o1;
    logic       sel1;
    logic [1:0] an1;
    logic       busy1;
    logic       valid1;
    logic       done1;

    adder_display_sequencer #(.REFRESH_CNT(4), .CNT_W(3)) dut4 (
        .clk(clk), .reset(reset), .go(go), .clear(clear),
        .A(a), .B(b), .Cin(cin),
        .O(o4), .Sel(sel4), .an(an4), .busy(busy4), .valid(valid4), .done(done4)
    );

    adder_display_sequencer #(.REFRESH_CNT(1), .CNT_W(1)) dut1 (
        .clk(clk), .reset(reset), .go(go), .clear(clear),
        .A(a), .B(b), .Cin(cin),
        .O(o1), .Sel(sel1), .an(an1), .busy(busy1), .valid(valid1), .done(done1)
    );

    int checks = 0;
    int errors = 0;

    // Model state per instance: mode 0 = idle, 1 = calc, 2 = show
    int         m_mode [2];
    int         m_t    [2];
    logic [3:0] m_a    [2];
    logic [3:0] m_b    [2];
    logic       m_c    [2];
    logic [4:0] m_res  [2];
    int         rc     [2] = '{4, 1};

    task automatic model_step(input int k);
        if (reset) begin
            m_mode[k] = 0;
            m_t[k]    = 0;
            m_a[k]    = 4'h0;
            m_b[k]    = 4'h0;
            m_c[k]    = 1'b0;
            m_res[k]  = 5'h00;
        end else if (clear) begin
            m_mode[k] = 0;
        end else if (m_mode[k] == 0) begin
            if (go) begin
                m_a[k] = a; m_b[k] = b; m_c[k] = cin;
                m_mode[k] = 1;
            end
        end else if (m_mode[k] == 1) begin
            m_res[k]  = 5'(m_a[k]) + 5'(m_b[k]) + 5'(m_c[k]);
            m_mode[k] = 2;
            m_t[k]    = 0;
        end else begin
            if (go) begin
                m_a[k] = a; m_b[k] = b; m_c[k] = cin;
                m_mode[k] = 1;
            end else begin
                m_t[k] = m_t[k] + 1;
            end
        end
    endtask

    // Expected {O, Sel, an, busy, valid, done}
    function automatic logic [9:0] expect_out(input int k);
        logic [4:0] r;
        r = m_res[k];
        if (m_mode[k] == 0) return {4'h0, 1'b0, 2'b11, 3'b000};
        if (m_mode[k] == 1) return {4'h0, 1'b0, 2'b11, 3'b100};
        if (((m_t[k] / rc[k]) % 2) == 0)
            return {r[3:0], 1'b1, 2'b10, 1'b0, 1'b1, (m_t[k] == 0)};
        return {3'b000, r[4], 1'b0, 2'b01, 3'b010};
    endfunction

    task automatic compare();
        logic [9:0] act [2];
        logic [9:0] exp_v;
        act[0] = {o4, sel4, an4, busy4, valid4, done4};
        act[1] = {o1, sel1, an1, busy1, valid1, done1};
        for (int k = 0; k < 2; k++) begin
            exp_v = expect_out(k);
            checks++;
            if (act[k] !== exp_v) begin
                errors++;
                $display("FAIL model_cmp R=%0d t=%0t got {O,Sel,an,busy,valid,done}=%b expected %b",
                         rc[k], $time, act[k], exp_v);
            end
        end
    endtask

    task automatic lit(input string name, input logic [3:0] act, input logic [3:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s t=%0t got %h expected %h", name, $time, act, exp_v);
        end
    endtask

    task automatic step(input logic g, input logic c, input logic r,
                        input logic [3:0] a_i, input logic [3:0] b_i, input logic c_i);
        go = g; clear = c; reset = r; a = a_i; b = b_i; cin = c_i;
        model_step(0);
        model_step(1);
        @(posedge clk);
        @(negedge clk);
        compare();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            step(1'b0, 1'b0, 1'b0, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                 1'($urandom_range(0, 1)));
    endtask

    initial begin
        // Reset and idle
        step(1'b0, 1'b0, 1'b1, 4'h0, 4'h0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 4'h0, 4'h0, 1'b0);
        idle(10);
        lit("idle_an", {2'b00, an4}, 4'h3);
        lit("idle_o", o4, 4'h0);

        // 9 + 8 + 0 = 0x11
        step(1'b1, 1'b0, 1'b0, 4'h9, 4'h8, 1'b0);
        lit("calc_busy", {3'b000, busy4}, 4'h1);
        idle(1);
        lit("first_done", {3'b000, done4}, 4'h1);
        lit("first_sum", o4, 4'h1);
        lit("first_an", {2'b00, an4}, 4'h2);
        lit("r1_sel_t0", {3'b000, sel1}, 4'h1);
        idle(3);
        lit("sum_t3_sel", {3'b000, sel4}, 4'h1);
        lit("r1_sel_t3", {3'b000, sel1}, 4'h0);
        idle(1);
        lit("carry_t4_sel", {3'b000, sel4}, 4'h0);
        lit("carry_t4_an", {2'b00, an4}, 4'h1);
        lit("carry_t4_o", o4, 4'h1);
        lit("r1_sel_t4", {3'b000, sel1}, 4'h1);
        idle(4);
        lit("sum_t8_sel", {3'b000, sel4}, 4'h1);

        // F + F + 1 = 0x1F
        step(1'b1, 1'b0, 1'b0, 4'hF, 4'hF, 1'b1);
        idle(1);
        lit("ff_sum", o4, 4'hF);
        idle(4);
        lit("ff_carry", o4, 4'h1);

        // 3 + 4 + 1 = 0x08
        step(1'b1, 1'b0, 1'b0, 4'h3, 4'h4, 1'b1);
        idle(1);
        lit("s8_sum", o4, 4'h8);
        idle(4);
        lit("s8_carry", o4, 4'h0);
        lit("s8_carry_sel", {3'b000, sel4}, 4'h0);

        // go mid-SHOW_C restarts from SHOW_S with a fresh count
        idle(1);
        step(1'b1, 1'b0, 1'b0, 4'h1, 4'h1, 1'b0);
        lit("rego_busy", {3'b000, busy4}, 4'h1);
        idle(1);
        lit("rego_sum", o4, 4'h2);
        lit("rego_done", {3'b000, done4}, 4'h1);
        idle(3);
        lit("rego_t3_sel", {3'b000, sel4}, 4'h1);
        idle(1);
        lit("rego_t4_sel", {3'b000, sel4}, 4'h0);

        // go during CALC is ignored
        step(1'b1, 1'b0, 1'b0, 4'h5, 4'h6, 1'b0);
        step(1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0);
        lit("calc_go_ignored", o4, 4'hB);

        // clear with go in SHOW_S wins
        idle(1);
        step(1'b1, 1'b1, 1'b0, 4'h7, 4'h7, 1'b0);
        lit("clear_an", {2'b00, an4}, 4'h3);
        lit("clear_busy", {3'b000, busy4}, 4'h0);
        idle(1);
        lit("clear_no_calc", {3'b000, busy4}, 4'h0);

        // reset mid-SHOW_S
        step(1'b1, 1'b0, 1'b0, 4'h2, 4'h2, 1'b0);
        idle(1);
        step(1'b0, 1'b0, 1'b1, 4'h0, 4'h0, 1'b0);
        lit("rst_o", o4, 4'h0);
        lit("rst_an", {2'b00, an4}, 4'h3);
        lit("rst_valid", {3'b000, valid4}, 4'h0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++)
            step(1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 59) == 0),
                 1'($urandom_range(0, 199) == 0), 4'($urandom_range(0, 15)),
                 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
